// File: rtl/butterfly_pipe_pkg.sv
// Shared defaults, butterfly mode encoding and the rounding-constant helper for butterfly_pipe.
package butterfly_pipe_pkg;

    localparam int DATA_W_DEF    = 16;
    localparam int TW_W_DEF      = 16;
    localparam int TW_ADDR_W_DEF = 3;

    typedef enum logic {
        MODE_DIT = 1'b0,
        MODE_DIF = 1'b1
    } mode_e;

    // Value added ahead of an arithmetic right shift by `shift` so the shift rounds half up.
    function automatic int round_const(input int shift);
        return (shift > 0) ? (1 << (shift - 1)) : 0;
    endfunction

endpackage

// File: rtl/twiddle_rom.sv
// Twiddle table W_k = exp(-j*pi*k/2**TW_ADDR_W) in Q1.(TW_W-1), built at elaboration.
// The read is registered (one-cycle latency) and only advances when ce is high.
module twiddle_rom
    import butterfly_pipe_pkg::*;
#(
    parameter int TW_W      = TW_W_DEF,
    parameter int TW_ADDR_W = TW_ADDR_W_DEF
) (
    input  logic                   clk,
    input  logic                   ce,
    input  logic [TW_ADDR_W-1:0]   addr,
    output logic signed [TW_W-1:0] w_re,
    output logic signed [TW_W-1:0] w_im
);

    localparam int  N   = 2 ** TW_ADDR_W;
    localparam real PI  = 3.14159265358979323846;
    localparam real AMP = real'((1 << (TW_W - 1)) - 1);

    function automatic int round_real(input real x);
        return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
    endfunction

    logic signed [TW_W-1:0] tab_re [N];
    logic signed [TW_W-1:0] tab_im [N];

    // Full-scale is 2**(TW_W-1)-1 so that W_0 = 1 stays representable.
    for (genvar k = 0; k < N; k++) begin : g_tab
        localparam real ANG = PI * real'(k) / real'(N);
        localparam int  RE  = round_real(AMP * $cos(ANG));
        localparam int  IM  = round_real(-AMP * $sin(ANG));
        assign tab_re[k] = TW_W'(RE);
        assign tab_im[k] = TW_W'(IM);
    end

    always_ff @(posedge clk) begin
        if (ce) begin
            w_re <= tab_re[addr];
            w_im <= tab_im[addr];
        end
    end

endmodule

// File: rtl/butterfly_pipe.sv
// Pipelined radix-2 complex butterfly, DIT or DIF selected per sample, fixed 4-cycle latency.
// Define BUTTERFLY_SAT_EN to saturate results and drive the sticky o_ovf flag; otherwise results wrap.
module butterfly_pipe
    import butterfly_pipe_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int TW_W      = TW_W_DEF,
    parameter int TW_ADDR_W = TW_ADDR_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_ce,
    input  logic                     i_valid,
    input  logic                     i_mode,
    input  logic                     i_scale,
    input  logic [TW_ADDR_W-1:0]     twiddle_num,
    input  logic signed [DATA_W-1:0] i_data_ra,
    input  logic signed [DATA_W-1:0] i_data_ca,
    input  logic signed [DATA_W-1:0] i_data_rb,
    input  logic signed [DATA_W-1:0] i_data_cb,
    output logic signed [DATA_W-1:0] o_data_ra,
    output logic signed [DATA_W-1:0] o_data_ca,
    output logic signed [DATA_W-1:0] o_data_rb,
    output logic signed [DATA_W-1:0] o_data_cb,
    output logic                     o_valid,
    output logic                     o_ovf
);

    localparam int XW = DATA_W + 1;
    localparam int PW = XW + TW_W + 1;
    localparam int MW = DATA_W + 3;
    localparam int SW = DATA_W + 4;
    localparam logic signed [PW-1:0] PROD_RND = PW'(round_const(TW_W - 1));

    function automatic logic signed [SW-1:0] half_up(input logic signed [SW-1:0] v);
        logic signed [SW:0] t;
        t = (SW+1)'(v) + (SW+1)'(1);
        return SW'(t >>> 1);
    endfunction

`ifdef BUTTERFLY_SAT_EN
    localparam logic signed [SW-1:0] MAX_S = {{(SW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [SW-1:0] MIN_S = ~MAX_S;

    function automatic logic over(input logic signed [SW-1:0] v);
        return (v > MAX_S) || (v < MIN_S);
    endfunction
`endif

    function automatic logic signed [DATA_W-1:0] narrow(input logic signed [SW-1:0] v);
`ifdef BUTTERFLY_SAT_EN
        if (v > MAX_S) return MAX_S[DATA_W-1:0];
        if (v < MIN_S) return MIN_S[DATA_W-1:0];
`endif
        return DATA_W'(v);
    endfunction

    logic signed [TW_W-1:0]   w_re_p0, w_im_p0, w_re_p1, w_im_p1;
    logic signed [DATA_W-1:0] a_re_p0, a_im_p0, b_re_p0, b_im_p0;
    mode_e                    mode_p0, mode_p1, mode_p2;
    logic                     scale_p0, scale_p1, scale_p2;
    logic                     vld_p0, vld_p1, vld_p2;
    logic signed [XW-1:0]     x_re, x_im, y_re, y_im;
    logic signed [XW-1:0]     x_re_p1, x_im_p1, y_re_p1, y_im_p1;
    logic signed [PW-1:0]     prod_re, prod_im;
    logic signed [MW-1:0]     m_re_p2, m_im_p2;
    logic signed [XW-1:0]     y_re_p2, y_im_p2;
    logic signed [SW-1:0]     sa_re, sa_im, sb_re, sb_im;

    twiddle_rom #(
        .TW_W      (TW_W),
        .TW_ADDR_W (TW_ADDR_W)
    ) u_twiddle_rom (
        .clk  (clk),
        .ce   (i_ce),
        .addr (twiddle_num),
        .w_re (w_re_p0),
        .w_im (w_im_p0)
    );

    // p0 -> p1: DIT forwards A and B; DIF forms A+B and A-B (optionally halved) ahead of the multiply
    always_comb begin
        x_re = XW'(b_re_p0);
        x_im = XW'(b_im_p0);
        y_re = XW'(a_re_p0);
        y_im = XW'(a_im_p0);
        if (mode_p0 == MODE_DIF) begin
            y_re = XW'(a_re_p0) + XW'(b_re_p0);
            y_im = XW'(a_im_p0) + XW'(b_im_p0);
            x_re = XW'(a_re_p0) - XW'(b_re_p0);
            x_im = XW'(a_im_p0) - XW'(b_im_p0);
            if (scale_p0) begin
                y_re = XW'(half_up(SW'(y_re)));
                y_im = XW'(half_up(SW'(y_im)));
                x_re = XW'(half_up(SW'(x_re)));
                x_im = XW'(half_up(SW'(x_im)));
            end
        end
    end

    // p1 -> p2: full-precision complex product, rounding constant folded in before the shift
    always_comb begin
        prod_re = PW'(x_re_p1) * PW'(w_re_p1) - PW'(x_im_p1) * PW'(w_im_p1) + PROD_RND;
        prod_im = PW'(x_re_p1) * PW'(w_im_p1) + PW'(x_im_p1) * PW'(w_re_p1) + PROD_RND;
    end

    // p2 -> output: DIT post-add (optionally halved); DIF results were finished upstream
    always_comb begin
        sa_re = SW'(y_re_p2) + SW'(m_re_p2);
        sa_im = SW'(y_im_p2) + SW'(m_im_p2);
        sb_re = SW'(y_re_p2) - SW'(m_re_p2);
        sb_im = SW'(y_im_p2) - SW'(m_im_p2);
        if (scale_p2) begin
            sa_re = half_up(sa_re);
            sa_im = half_up(sa_im);
            sb_re = half_up(sb_re);
            sb_im = half_up(sb_im);
        end
        if (mode_p2 == MODE_DIF) begin
            sa_re = SW'(y_re_p2);
            sa_im = SW'(y_im_p2);
            sb_re = SW'(m_re_p2);
            sb_im = SW'(m_im_p2);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else if (i_ce) begin
            vld_p0 <= i_valid;
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_ce) begin
            a_re_p0  <= i_data_ra;
            a_im_p0  <= i_data_ca;
            b_re_p0  <= i_data_rb;
            b_im_p0  <= i_data_cb;
            mode_p0  <= mode_e'(i_mode);
            scale_p0 <= i_scale;

            x_re_p1  <= x_re;
            x_im_p1  <= x_im;
            y_re_p1  <= y_re;
            y_im_p1  <= y_im;
            w_re_p1  <= w_re_p0;
            w_im_p1  <= w_im_p0;
            mode_p1  <= mode_p0;
            scale_p1 <= scale_p0;

            m_re_p2  <= MW'(prod_re >>> (TW_W - 1));
            m_im_p2  <= MW'(prod_im >>> (TW_W - 1));
            y_re_p2  <= y_re_p1;
            y_im_p2  <= y_im_p1;
            mode_p2  <= mode_p1;
            scale_p2 <= scale_p1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_valid   <= 1'b0;
            o_data_ra <= '0;
            o_data_ca <= '0;
            o_data_rb <= '0;
            o_data_cb <= '0;
        end else if (i_ce) begin
            o_valid <= vld_p2;
            if (vld_p2) begin
                o_data_ra <= narrow(sa_re);
                o_data_ca <= narrow(sa_im);
                o_data_rb <= narrow(sb_re);
                o_data_cb <= narrow(sb_im);
            end
        end
    end

`ifdef BUTTERFLY_SAT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            o_ovf <= 1'b0;
        end else if (i_ce && vld_p2 &&
                     (over(sa_re) || over(sa_im) || over(sb_re) || over(sb_im))) begin
            o_ovf <= 1'b1;
        end
    end
`else
    assign o_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_butterfly_pipe.sv
// Scoreboard bench for butterfly_pipe: directed vectors push expected results, a negedge monitor
// pops and compares whenever the pipeline presents a new output, and checks hold behaviour otherwise.
module tb_butterfly_pipe;

    typedef struct {
        int mode; int scale; int k;
        int ar; int ai; int br; int bi;
        int ea_r; int ea_i; int eb_r; int eb_i;
        int sat;
    } vec_t;

    typedef struct {
        int ra; int ca; int rb; int cb; int ovf;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_ce;
    logic              i_valid;
    logic              i_mode;
    logic              i_scale;
    logic [2:0]        twiddle_num;
    logic signed [15:0] i_data_ra, i_data_ca, i_data_rb, i_data_cb;
    logic signed [15:0] o_data_ra, o_data_ca, o_data_rb, o_data_cb;
    logic              o_valid;
    logic              o_ovf;

    int   checks = 0;
    int   errors = 0;
    int   ovf_model = 0;
    exp_t sb[$];
    exp_t last;
    exp_t mon_e;
    vec_t tbl[10];
    logic [3:0] vpipe = '0;
    logic was_rst = 1'b0;
    logic was_adv = 1'b0;

    butterfly_pipe dut (
        .clk         (clk),
        .rst         (rst),
        .i_ce        (i_ce),
        .i_valid     (i_valid),
        .i_mode      (i_mode),
        .i_scale     (i_scale),
        .twiddle_num (twiddle_num),
        .i_data_ra   (i_data_ra),
        .i_data_ca   (i_data_ca),
        .i_data_rb   (i_data_rb),
        .i_data_cb   (i_data_cb),
        .o_data_ra   (o_data_ra),
        .o_data_ca   (o_data_ca),
        .o_data_rb   (o_data_rb),
        .o_data_cb   (o_data_cb),
        .o_valid     (o_valid),
        .o_ovf       (o_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int idx);
        vec_t t;
        exp_t e;
        t = tbl[idx];
        i_valid     = 1'b1;
        i_mode      = 1'(t.mode);
        i_scale     = 1'(t.scale);
        twiddle_num = 3'(t.k);
        i_data_ra   = 16'(t.ar);
        i_data_ca   = 16'(t.ai);
        i_data_rb   = 16'(t.br);
        i_data_cb   = 16'(t.bi);
        ovf_model   = ovf_model | t.sat;
        e = '{ra: t.ea_r, ca: t.ea_i, rb: t.eb_r, cb: t.eb_i, ovf: ovf_model};
        sb.push_back(e);
        tick(1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            tick(1);
            n++;
        end
        chk("drain_pending", sb.size(), 0);
        tick(2);
    endtask

    // Latency model: a sample accepted on an advancing edge emerges four advancing edges later.
    always @(posedge clk) begin
        was_rst <= rst;
        was_adv <= i_ce;
        if (rst) begin
            vpipe <= '0;
            sb.delete();
        end else if (i_ce) begin
            vpipe <= {vpipe[2:0], i_valid};
        end
    end

    always @(negedge clk) begin
        if (was_rst) begin
            chk("rst_o_valid", o_valid, 0);
            chk("rst_o_ovf", o_ovf, 0);
            chk("rst_ra", o_data_ra, 0);
            chk("rst_ca", o_data_ca, 0);
            chk("rst_rb", o_data_rb, 0);
            chk("rst_cb", o_data_cb, 0);
            last = '{default: 0};
        end else begin
            chk("o_valid", o_valid, vpipe[3]);
            if (was_adv && vpipe[3]) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_output: got o_valid with empty scoreboard at %0t", $time);
                end else begin
                    mon_e = sb.pop_front();
                    last = mon_e;
                end
            end
            chk("out_ra", o_data_ra, last.ra);
            chk("out_ca", o_data_ca, last.ca);
            chk("out_rb", o_data_rb, last.rb);
            chk("out_cb", o_data_cb, last.cb);
            chk("o_ovf", o_ovf, last.ovf);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; i_ce = 1'b1; i_valid = 1'b0; i_mode = 1'b0; i_scale = 1'b0;
        twiddle_num = '0;
        i_data_ra = '0; i_data_ca = '0; i_data_rb = '0; i_data_cb = '0;

        // mode, scale, k, A(re,im), B(re,im), out_a(re,im), out_b(re,im), saturates
        tbl[0] = '{0, 0, 0,   1000,    0,   2000,    0,   3000,     0,  -1000,    0, 0};
        tbl[1] = '{0, 0, 4,   1000,    0,   2000,    0,   1000, -2000,   1000, 2000, 0};
        tbl[2] = '{1, 0, 0,   3000,  500,   1000,  500,   4000,  1000,   2000,    0, 0};
        tbl[3] = '{0, 1, 0,  32767,    0,  32767,    0,  32767,     0,      1,    0, 0};
`ifdef BUTTERFLY_SAT_EN
        tbl[4] = '{0, 0, 0,  32767,    0,  32767,    0,  32767,     0,      1,    0, 1};
        tbl[9] = '{0, 0, 0, -32768,    0, -32768,    0, -32768,     0,     -1,    0, 1};
`else
        tbl[4] = '{0, 0, 0,  32767,    0,  32767,    0,     -3,     0,      1,    0, 0};
        tbl[9] = '{0, 0, 0, -32768,    0, -32768,    0,      1,     0,     -1,    0, 0};
`endif
        tbl[5] = '{1, 0, 4,    100,  200,   -300,   50,   -200,   250,    150, -400, 0};
        tbl[6] = '{0, 0, 2,      0,    0,   1000,    0,    707,  -707,   -707,  707, 0};
        tbl[7] = '{0, 1, 6,    500, -500,      0, 1000,    604,  -603,   -103,  104, 0};
        tbl[8] = '{1, 1, 2,   1001,   -3,     -1,    1,    500,    -1,    353, -356, 0};

        tick(3);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) send(i);
        i_valid = 1'b0;
        drain();

        for (int i = 0; i < 10; i++) begin
            if (i == 5) begin
                i_valid = 1'b0;
                i_ce = 1'b0;
                tick(3);
                i_ce = 1'b1;
            end
            send(i);
        end
        i_valid = 1'b0;
        drain();

        send(0);
        send(1);
        send(2);
        i_valid = 1'b0;
        i_ce = 1'b0;
        rst = 1'b1;
        ovf_model = 0;
        tick(1);
        rst = 1'b0;
        i_ce = 1'b1;
        tick(6);

        send(1);
        i_valid = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
